// File: rtl/reindeer_decode_pkg.sv
// Shared constants and types for the Reindeer decode queue: opcodes, SYSTEM funct12 codes,
// control-vector bit indices and the stored decode word.
package reindeer_decode_pkg;

  localparam logic [4:0] CMD_LOAD     = 5'b00000;
  localparam logic [4:0] CMD_MISC_MEM = 5'b00011;
  localparam logic [4:0] CMD_OP_IMM   = 5'b00100;
  localparam logic [4:0] CMD_AUIPC    = 5'b00101;
  localparam logic [4:0] CMD_STORE    = 5'b01000;
  localparam logic [4:0] CMD_OP       = 5'b01100;
  localparam logic [4:0] CMD_LUI      = 5'b01101;
  localparam logic [4:0] CMD_BRANCH   = 5'b11000;
  localparam logic [4:0] CMD_JALR     = 5'b11001;
  localparam logic [4:0] CMD_JAL      = 5'b11011;
  localparam logic [4:0] CMD_SYSTEM   = 5'b11100;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  localparam int unsigned CTL_BITS = 22;

  localparam int unsigned CTL_X_RS1       = 0;
  localparam int unsigned CTL_Y_RS2       = 1;
  localparam int unsigned CTL_Y_IMM12     = 2;
  localparam int unsigned CTL_Y_STORE_OFF = 3;
  localparam int unsigned CTL_SAVE_RD     = 4;
  localparam int unsigned CTL_ALU         = 5;
  localparam int unsigned CTL_MUL_DIV     = 6;
  localparam int unsigned CTL_LUI         = 7;
  localparam int unsigned CTL_AUIPC       = 8;
  localparam int unsigned CTL_JAL         = 9;
  localparam int unsigned CTL_JALR        = 10;
  localparam int unsigned CTL_BRANCH      = 11;
  localparam int unsigned CTL_LOAD        = 12;
  localparam int unsigned CTL_STORE       = 13;
  localparam int unsigned CTL_SYSTEM      = 14;
  localparam int unsigned CTL_CSR         = 15;
  localparam int unsigned CTL_CSR_WRITE   = 16;
  localparam int unsigned CTL_MISC_MEM    = 17;
  localparam int unsigned CTL_MRET        = 18;
  localparam int unsigned CTL_WFI         = 19;
  localparam int unsigned CTL_ECALL       = 20;
  localparam int unsigned CTL_EBREAK      = 21;

  typedef struct packed {
    logic [CTL_BITS-1:0] ctl;
    logic                illegal;
    logic                csr_read_enable;
  } decode_t;

endpackage

// File: rtl/reindeer_decode_logic.sv
// Combinational RV32I(+M) decoder: instruction word to control vector, illegal flag and
// CSR read qualification.
module reindeer_decode_logic
  import reindeer_decode_pkg::*;
#(
  parameter int unsigned MUL_DIV_EN = 1
) (
  input  logic [31:0]         i_ir,
  output logic [CTL_BITS-1:0] o_ctl,
  output logic                o_illegal,
  output logic                o_csr_read_enable
);

  logic [4:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [11:0]         w_funct12;
  logic [CTL_BITS-1:0] w_ctl;
  logic                w_illegal;

  assign w_opcode  = i_ir[6:2];
  assign w_funct3  = i_ir[14:12];
  assign w_funct7  = i_ir[31:25];
  assign w_funct12 = i_ir[31:20];

  always_comb begin
    w_ctl     = '0;
    w_illegal = 1'b0;
    if (i_ir[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      unique case (w_opcode)
        CMD_OP_IMM: begin
          w_ctl[CTL_X_RS1]   = 1'b1;
          w_ctl[CTL_Y_IMM12] = 1'b1;
          w_ctl[CTL_SAVE_RD] = 1'b1;
          w_ctl[CTL_ALU]     = 1'b1;
        end
        CMD_OP: begin
          if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000 ||
              (MUL_DIV_EN != 0 && w_funct7 == 7'b0000001)) begin
            w_ctl[CTL_X_RS1]   = 1'b1;
            w_ctl[CTL_Y_RS2]   = 1'b1;
            w_ctl[CTL_SAVE_RD] = 1'b1;
            if (i_ir[25]) w_ctl[CTL_MUL_DIV] = 1'b1;
            else          w_ctl[CTL_ALU]     = 1'b1;
          end else begin
            w_illegal = 1'b1;
          end
        end
        CMD_LUI: begin
          w_ctl[CTL_LUI]     = 1'b1;
          w_ctl[CTL_SAVE_RD] = 1'b1;
        end
        CMD_AUIPC: begin
          w_ctl[CTL_AUIPC]   = 1'b1;
          w_ctl[CTL_SAVE_RD] = 1'b1;
        end
        CMD_JAL: begin
          w_ctl[CTL_JAL]     = 1'b1;
          w_ctl[CTL_SAVE_RD] = 1'b1;
        end
        CMD_JALR: begin
          w_ctl[CTL_JALR]    = 1'b1;
          w_ctl[CTL_SAVE_RD] = 1'b1;
          w_ctl[CTL_X_RS1]   = 1'b1;
        end
        CMD_BRANCH: begin
          w_ctl[CTL_BRANCH] = 1'b1;
          w_ctl[CTL_X_RS1]  = 1'b1;
          w_ctl[CTL_Y_RS2]  = 1'b1;
        end
        // Loads write back from the memory stage, so SAVE_RD stays clear here.
        CMD_LOAD: begin
          w_ctl[CTL_LOAD]  = 1'b1;
          w_ctl[CTL_X_RS1] = 1'b1;
        end
        CMD_STORE: begin
          w_ctl[CTL_STORE]       = 1'b1;
          w_ctl[CTL_X_RS1]       = 1'b1;
          w_ctl[CTL_Y_RS2]       = 1'b1;
          w_ctl[CTL_Y_STORE_OFF] = 1'b1;
        end
        CMD_MISC_MEM: begin
          w_ctl[CTL_MISC_MEM] = 1'b1;
        end
        CMD_SYSTEM: begin
          w_ctl[CTL_SYSTEM] = 1'b1;
          w_ctl[CTL_X_RS1]  = 1'b1;
          if (w_funct3 == 3'b000) begin
            unique case (w_funct12)
              F12_ECALL:  w_ctl[CTL_ECALL]  = 1'b1;
              F12_EBREAK: w_ctl[CTL_EBREAK] = 1'b1;
              F12_MRET:   w_ctl[CTL_MRET]   = 1'b1;
              F12_WFI:    w_ctl[CTL_WFI]    = 1'b1;
              default:    w_illegal         = 1'b1;
            endcase
          end else if (w_funct3 == 3'b100) begin
            w_illegal = 1'b1;
          end else begin
            w_ctl[CTL_CSR]       = 1'b1;
            w_ctl[CTL_SAVE_RD]   = 1'b1;
            // Set/clear forms with rs1/uimm == 0 must not write the CSR.
            w_ctl[CTL_CSR_WRITE] = (w_funct3[1:0] == 2'b01) || (i_ir[19:15] != 5'd0);
          end
        end
        default: w_illegal = 1'b1;
      endcase
    end
    if (w_illegal) w_ctl = '0;
  end

  assign o_ctl             = w_ctl;
  assign o_illegal         = w_illegal;
  assign o_csr_read_enable = w_ctl[CTL_CSR] & ~((w_funct3[1:0] == 2'b01) & (i_ir[11:7] == 5'd0));

endmodule

// File: rtl/reindeer_decode_queue.sv
// Buffered decode stage: decodes fetched {IR, PC} at push time and holds up to DEPTH decoded
// entries in a circular queue whose head feeds execute.
module reindeer_decode_queue
  import reindeer_decode_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned PC_BITWIDTH = 32,
  parameter int unsigned MUL_DIV_EN  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                IR_in,
  input  logic [PC_BITWIDTH-1:0]     PC_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                IR_out,
  output logic [PC_BITWIDTH-1:0]     PC_out,
  output logic [4:0]                 rs1,
  output logic [4:0]                 rs2,
  output logic [4:0]                 rd,
  output logic [11:0]                csr,
  output logic [CTL_BITS-1:0]        ctl,
  output logic                       csr_read_enable,
  output logic                       illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]             r_ir  [DEPTH];
  logic [PC_BITWIDTH-1:0]  r_pc  [DEPTH];
  decode_t                 r_dec [DEPTH];
  logic [PtrW-1:0]         r_wr_ptr;
  logic [PtrW-1:0]         r_rd_ptr;
  logic [CntW-1:0]         r_count;

  decode_t w_dec;
  logic    w_push;
  logic    w_pop;

  reindeer_decode_logic #(
    .MUL_DIV_EN(MUL_DIV_EN)
  ) u_decode (
    .i_ir              (IR_in),
    .o_ctl             (w_dec.ctl),
    .o_illegal         (w_dec.illegal),
    .o_csr_read_enable (w_dec.csr_read_enable)
  );

  assign in_ready  = (r_count != Full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_ir[r_wr_ptr]  <= IR_in;
        r_pc[r_wr_ptr]  <= PC_in;
        r_dec[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Head is masked when empty so stale storage never leaks to execute.
  always_comb begin
    IR_out          = '0;
    PC_out          = '0;
    ctl             = '0;
    illegal         = 1'b0;
    csr_read_enable = 1'b0;
    if (out_valid) begin
      IR_out          = r_ir[r_rd_ptr];
      PC_out          = r_pc[r_rd_ptr];
      ctl             = r_dec[r_rd_ptr].ctl;
      illegal         = r_dec[r_rd_ptr].illegal;
      csr_read_enable = r_dec[r_rd_ptr].csr_read_enable;
    end
  end

  assign rs1 = IR_out[19:15];
  assign rs2 = IR_out[24:20];
  assign rd  = IR_out[11:7];
  assign csr = IR_out[31:20];

endmodule

// File: doc/reindeer_decode_queue.md
# reindeer_decode_queue

Buffered, parametrised instruction-decode stage for the Reindeer core: accepts fetched {IR, PC} pairs over a valid/ready handshake, decodes each at push time into a control vector plus illegal flag, and holds up to DEPTH decoded entries in a circular queue. The queue head drives the execute stage with registered outputs. The block sits between instruction fetch and execute, absorbs execute stalls, and adds illegal-opcode detection, ECALL/EBREAK decode, and spec-correct CSR read/write qualification.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2.
- PC_BITWIDTH, 32, PC width.
- MUL_DIV_EN, 1, 1 = RV32M legal; 0 = funct7 0000001 under OP is illegal.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard all queued entries and any same-cycle push (branch, trap or MRET redirect).
- in_valid  in  1  fetch presents IR_in/PC_in.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- IR_in  in  32  instruction word.
- PC_in  in  PC_BITWIDTH  instruction address.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  execute consumes the head.
- IR_out, PC_out  out  32 / PC_BITWIDTH  head entry.
- rs1, rs2, rd  out  5 each  IR_out[19:15], [24:20], [11:7].
- csr  out  12  IR_out[31:20].
- ctl  out  CTL_BITS  one bit per control flag (indices in package); all zero when !out_valid.
- csr_read_enable  out  1  head is a CSR op that must read the CSR.
- illegal  out  1  head is an illegal instruction; 0 when !out_valid.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push = in_valid & in_ready; pop = out_valid & out_ready. The decoded word {ctl, illegal, csr_read_enable} is stored alongside IR/PC on push.
- Per-cycle priority: reset > flush > push/pop. Flush clears count, wr_ptr, rd_ptr; that cycle's push and pop are dropped.
- Simultaneous push and pop with count in 1..DEPTH-1 leaves count unchanged. When full, in_ready=0 even if pop is asserted.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Illegal: IR[1:0]≠11; opcode[6:2] not in {OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM, MISC_MEM}; OP funct7 not in {0000000, 0100000, 0000001(MUL_DIV_EN only)}; SYSTEM funct3=100. An illegal entry has ctl=0 and csr_read_enable=0.
- OP_IMM: X_RS1, Y_IMM12, SAVE_RD, ALU.
- OP: X_RS1, Y_RS2, SAVE_RD, plus ALU or MUL_DIV selected by IR[25].
- LUI: LUI, SAVE_RD. AUIPC: AUIPC, SAVE_RD. JAL: JAL, SAVE_RD. JALR: JALR, SAVE_RD, X_RS1.
- BRANCH: BRANCH, X_RS1, Y_RS2.
- LOAD: LOAD, X_RS1. SAVE_RD stays 0; the memory stage performs the writeback.
- STORE: STORE, X_RS1, Y_RS2, Y_STORE_OFF.
- MISC_MEM: MISC_MEM.
- SYSTEM always sets SYSTEM and X_RS1. With funct3=000: funct12 0x000 → ECALL, 0x001 → EBREAK, 0x302 → MRET, 0x105 → WFI; any other funct12 is illegal. Otherwise sets CSR and SAVE_RD.
- CSR_WRITE: set for CSRRW/CSRRWI (funct3[1:0]=01); set for CSRRS/CSRRC and their I-forms only when IR[19:15]≠0.
- csr_read_enable = CSR & !(funct3[1:0]=01 & rd=0).

## Timing
- Reset: count=0, pointers=0, IR_out=0, PC_out=0, out_valid=0, in_ready=1, ctl=0, illegal=0, csr_read_enable=0.
- Latency: a push in cycle N into an empty queue gives out_valid=1 with that entry in cycle N+1. There is no combinational path from in_valid or IR_in to any output.
- in_ready and out_valid depend on count only, so there is no combinational ready/valid loop.
- Head outputs are storage reads indexed by a registered pointer and a registered count. Rd/ctl follow the new head in the cycle after a pop.
- Flush in cycle N gives out_valid=0 and in_ready=1 in cycle N+1.

## Structure
- Package reindeer_decode_pkg holds: opcode constants (CMD_*), SYSTEM funct12 constants, CTL_BITS, and the index constants CTL_X_RS1, CTL_Y_RS2, CTL_Y_IMM12, CTL_Y_STORE_OFF, CTL_SAVE_RD, CTL_ALU, CTL_MUL_DIV, CTL_LUI, CTL_AUIPC, CTL_JAL, CTL_JALR, CTL_BRANCH, CTL_LOAD, CTL_STORE, CTL_SYSTEM, CTL_CSR, CTL_CSR_WRITE, CTL_MISC_MEM, CTL_MRET, CTL_WFI, CTL_ECALL, CTL_EBREAK (22 bits).
- One purely combinational sub-module, reindeer_decode_logic: IR in → {ctl, illegal, csr_read_enable} out, parametrised by MUL_DIV_EN.
- The top level holds the queue storage, pointers and count.

## Test plan
- After reset, push 0x00500093 (addi x1,x0,5) with out_ready=0 → next cycle out_valid=1, ctl = X_RS1|Y_IMM12|SAVE_RD|ALU, rd=1, count=1.
- DEPTH=2, push 3 back-to-back with out_ready=0 → in_ready=0 after 2 pushes, third not accepted. Assert out_ready → entries leave in order, count returns to 0 with no loss.
- Queue at count=1, push and pop together for 10 cycles → count stays 1, PC_out advances each cycle.
- Flush with count=2 while in_valid=1 → next cycle count=0, out_valid=0, and the flushed-cycle instruction never appears at the output.
- Push 0x02208033 (mul) with MUL_DIV_EN=0 → illegal=1, ctl=0. Repeat with MUL_DIV_EN=1 → MUL_DIV=1, illegal=0.
- Push 0x34001073 (csrrw x0,mscratch,x0) → CSR_WRITE=1, csr_read_enable=0. Push 0x34002573 (csrrs a0,mscratch,x0) → CSR_WRITE=0, csr_read_enable=1. Push 0x00100073 → EBREAK=1. Push 0x0000007F → illegal=1.
